// File: rtl/fofb_xy_buf_ctrl.sv
// rtl/fofb_xy_buf_ctrl.sv - FOFB ping-pong X/Y capture buffer for PCIe DMA (optional bank clear: FOFB_XY_BUF_CLEAR_EN)
module fofb_xy_buf_ctrl #(
    parameter int NODES = 512,
    parameter int CNT_W = 16
) (
    input  logic             trn_clk,
    input  logic             trn_reset_n,
    input  logic             pkt_valid_i,
    input  logic [9:0]       pkt_id_i,
    input  logic [31:0]      pkt_x_i,
    input  logic [31:0]      pkt_y_i,
    input  logic             timeframe_start_i,
    input  logic             timeframe_end_i,
    input  logic [9:0]       xy_buf_addr_i,
    output logic [63:0]      xy_buf_dat_o,
    output logic             timeframe_end_rise_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] frame_cnt_o
);
    localparam int AW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [10:0] NODES_L = 11'(NODES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              wr_bank;
    logic              end_q;
    logic              accept;
    logic              drop;
    logic              start_pend;
    logic [CNT_W-1:0]  frame_pkt_cnt;
    logic              id_in_range;
    logic              rd_in_range;
    logic              wr_en_q;
    logic              wr_sel_q;
    logic [AW-1:0]     wr_addr_q;
    logic [63:0]       wr_data_q;

    // Two physical banks so a frame-end packet write and the first clear word never share a port.
    logic [63:0] mem0 [NODES];
    logic [63:0] mem1 [NODES];

    assign id_in_range = ({1'b0, pkt_id_i} < NODES_L);
    assign rd_in_range = ({1'b0, xy_buf_addr_i} < NODES_L);

`ifdef FOFB_XY_BUF_CLEAR_EN
    logic [AW-1:0] clr_addr;
    logic          clr_last;
    logic          clr_we;
    logic          clr_bank;

    assign clr_last = (clr_addr == AW'(NODES - 1));
    // On the first clear cycle wr_bank has not toggled yet, so the target is its complement.
    assign clr_bank = wr_bank ^ end_q;

    // Clear address walk and latching of a frame start that arrives while clearing.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            clr_addr   <= '0;
            start_pend <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
            end
            if (state == CLEAR && timeframe_start_i) begin
                start_pend <= 1'b1;
            end else if (state == IDLE) begin
                start_pend <= 1'b0;
            end
        end
    end
`else
    assign start_pend = 1'b0;
`endif

    // State register.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (timeframe_start_i || start_pend) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (timeframe_end_i) begin
`ifdef FOFB_XY_BUF_CLEAR_EN
                    state_nxt = CLEAR;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef FOFB_XY_BUF_CLEAR_EN
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state outputs: packet accept/drop and clear write enable.
    always_comb begin
        accept = 1'b0;
`ifdef FOFB_XY_BUF_CLEAR_EN
        clr_we = 1'b0;
`endif
        case (state)
            CAPTURE: accept = pkt_valid_i && id_in_range;
`ifdef FOFB_XY_BUF_CLEAR_EN
            CLEAR:   clr_we = 1'b1;
`endif
            default: ;
        endcase
        drop = pkt_valid_i && !accept;
    end

    // Write pipeline, bank swap on the edge after frame end, and status counters.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            wr_en_q              <= 1'b0;
            wr_sel_q             <= 1'b0;
            wr_addr_q            <= '0;
            wr_data_q            <= '0;
            wr_bank              <= 1'b0;
            end_q                <= 1'b0;
            timeframe_end_rise_o <= 1'b0;
            frame_pkt_cnt        <= '0;
            pkt_cnt_o            <= '0;
            drop_cnt_o           <= '0;
            frame_cnt_o          <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_sel_q  <= wr_bank;
                wr_addr_q <= pkt_id_i[AW-1:0];
                wr_data_q <= {pkt_y_i, pkt_x_i};
            end
            end_q                <= (state == CAPTURE) && timeframe_end_i;
            timeframe_end_rise_o <= end_q;
            if (end_q) begin
                wr_bank       <= ~wr_bank;
                pkt_cnt_o     <= frame_pkt_cnt;
                frame_pkt_cnt <= '0;
                frame_cnt_o   <= frame_cnt_o + CNT_W'(1);
            end else if (accept && frame_pkt_cnt != CNT_MAX) begin
                frame_pkt_cnt <= frame_pkt_cnt + CNT_W'(1);
            end
            if (drop && drop_cnt_o != CNT_MAX) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end

    // RAM writes: captured packets into their bank, clear words into the new capture bank.
    always_ff @(posedge trn_clk) begin
        if (wr_en_q && !wr_sel_q) begin
            mem0[wr_addr_q] <= wr_data_q;
        end
        if (wr_en_q && wr_sel_q) begin
            mem1[wr_addr_q] <= wr_data_q;
        end
`ifdef FOFB_XY_BUF_CLEAR_EN
        if (clr_we && !clr_bank) begin
            mem0[clr_addr] <= '0;
        end
        if (clr_we && clr_bank) begin
            mem1[clr_addr] <= '0;
        end
`endif
    end

    // Registered read of the frozen bank; addresses beyond NODES return zero.
    always_ff @(posedge trn_clk) begin
        if (!rd_in_range) begin
            xy_buf_dat_o <= '0;
        end else if (wr_bank) begin
            xy_buf_dat_o <= mem0[xy_buf_addr_i[AW-1:0]];
        end else begin
            xy_buf_dat_o <= mem1[xy_buf_addr_i[AW-1:0]];
        end
    end
endmodule
